dbg_slave_sysclk_cdc: RTL
=========================

Name: dbg_slave_sysclk_cdc

Overview:
- System-clock side of the JTAG debug slave, generalised successor to the fixed 2-bit-IR / 38-bit-DR sysclk block.
- Synchronises the virtual-JTAG update-DR and update-IR strobes into clk, captures the scanned shift register with its instruction, and queues commands in a small FIFO.
- The CPU debug logic consumes commands through a valid/ready handshake, so back-to-back JTAG updates are not lost.
- Adds sticky overflow reporting and spurious-edge suppression after reset.

Parameters:
DR_WIDTH, 38, width of scanned data register sr / jdo
IR_WIDTH, 2, width of virtual IR; decoded into 2**IR_WIDTH one-hot lines
SYNC_DEPTH, 2, synchroniser flops per strobe (legal range 2..4)
QUEUE_DEPTH, 4, command FIFO entries (power of 2, at least 2)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
vs_udr  in  1  virtual update-DR state, TCK domain, asynchronous to clk
vs_uir  in  1  virtual update-IR state, TCK domain, asynchronous to clk
ir_in  in  IR_WIDTH  virtual IR value, quasi-static
sr  in  DR_WIDTH  scanned data register, quasi-static
jdo  out  DR_WIDTH  data of FIFO head entry
cmd_ir  out  IR_WIDTH  IR of FIFO head entry
cmd_valid  out  1  FIFO non-empty
cmd_ready  in  1  consumer accepts head this cycle
cmd_onehot  out  2**IR_WIDTH  one-hot decode of cmd_ir, gated by cmd_valid
ir_update  out  1  one-cycle pulse on each synchronised update-IR
ir_latched  out  IR_WIDTH  IR captured at last ir_update
queue_level  out  clog2(QUEUE_DEPTH)+1  current entry count
overflow  out  1  sticky: an update-DR was dropped
overflow_clr  in  1  clears overflow

Behaviour:
- Reset values: all synchroniser flops 0, FIFO empty, cmd_valid 0, jdo 0, cmd_ir 0, cmd_onehot 0, ir_update 0, ir_latched 0, queue_level 0, overflow 0. Reset mid-operation discards all queued entries.
- Synchroniser: each strobe passes through SYNC_DEPTH flops, then an edge register; rise = sync_out & ~edge_reg.
- Host guarantees:
  - vs_udr / vs_uir stay high for at least SYNC_DEPTH+2 clk cycles and low for at least SYNC_DEPTH+2 clk cycles between strobes.
  - sr and ir_in stay stable from strobe rise until SYNC_DEPTH+2 clk cycles after it.
- Arm flags (one per strobe): cleared by reset, set on the first cycle the synchronised strobe is 0. A rise is honoured only while armed, so a strobe already high at reset release produces no event.
- Update-DR rise: writes {ir_in, sr} into the FIFO in that cycle.
  - Latency: edge 0 is the first clk edge sampling vs_udr high. The push occurs at edge SYNC_DEPTH; cmd_valid, jdo and cmd_ir are valid after edge SYNC_DEPTH.
- Update-IR rise: ir_update is high for exactly one cycle after edge SYNC_DEPTH; ir_latched loads ir_in on the same edge.
- FIFO:
  - First-word-fall-through; head is registered.
  - Pop when cmd_valid & cmd_ready. cmd_ready while empty is ignored.
  - Push accepted when count < QUEUE_DEPTH, or when a pop happens in the same cycle (count unchanged).
  - Push while full with no pop: entry dropped, overflow set, FIFO contents untouched.
  - Pointers wrap modulo QUEUE_DEPTH.
  - queue_level = count, updated the same edge as push/pop.
- overflow: set on a drop, cleared on overflow_clr. Set wins if both occur in the same cycle.
- cmd_onehot[cmd_ir] = cmd_valid, all other bits 0 (combinational from registered head).
- Update-DR and update-IR rises in the same cycle are both processed independently.

Test Plan:
- Reset release with vs_udr held high, then hold high 20 cycles -> no push, cmd_valid stays 0. Then drop low, raise again with sr=38'h2_1234_5678, ir_in=2 -> cmd_valid after edge 2, jdo=38'h2_1234_5678, cmd_ir=2, cmd_onehot=4'b0100.
- Four update-DR strobes with sr=1,2,3,4 and cmd_ready=0 -> queue_level 4. A fifth (sr=5) -> dropped, overflow=1. Pop four -> jdo sequence 1,2,3,4, then cmd_valid=0.
- FIFO full with cmd_ready=1 held on the cycle a new push arrives -> entry accepted, queue_level stays 4, overflow stays 0.
- Update-IR strobe with ir_in=3 -> single-cycle ir_update after edge 2, ir_latched=3. Simultaneous update-DR/update-IR -> both events observed in the same cycle.
- overflow_clr asserted on the same cycle as a new drop -> overflow remains 1. overflow_clr alone next cycle -> overflow 0.
- Assert reset with 3 entries queued and a strobe in flight -> all outputs return to reset values immediately, and no stale push appears after release.

Source files
------------

// File: rtl/dbg_slave_sysclk_cdc.sv
// dbg_slave_sysclk_cdc: syncs JTAG update strobes into clk and queues {ir, dr} commands
module dbg_slave_sysclk_cdc #(
  parameter int DR_WIDTH    = 38,
  parameter int IR_WIDTH    = 2,
  parameter int SYNC_DEPTH  = 2,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             vs_udr,
  input  logic                             vs_uir,
  input  logic [IR_WIDTH-1:0]              ir_in,
  input  logic [DR_WIDTH-1:0]              sr,
  output logic [DR_WIDTH-1:0]              jdo,
  output logic [IR_WIDTH-1:0]              cmd_ir,
  output logic                             cmd_valid,
  input  logic                             cmd_ready,
  output logic [(2**IR_WIDTH)-1:0]         cmd_onehot,
  output logic                             ir_update,
  output logic [IR_WIDTH-1:0]              ir_latched,
  output logic [$clog2(QUEUE_DEPTH):0]     queue_level,
  output logic                             overflow,
  input  logic                             overflow_clr
);
  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int LW = AW + 1;
  localparam int NL = 2 ** IR_WIDTH;
  localparam int EW = IR_WIDTH + DR_WIDTH;
  logic [SYNC_DEPTH-1:0] udr_sync, uir_sync, fill;
  logic udr_edge, uir_edge, udr_armed, uir_armed;
  logic udr_out, uir_out, udr_rise, uir_rise;
  logic [EW-1:0] mem [QUEUE_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [LW-1:0] count;
  logic pop, push_ok, drop;
  assign udr_out = udr_sync[SYNC_DEPTH-1];
  assign uir_out = uir_sync[SYNC_DEPTH-1];
  assign udr_rise = udr_out & ~udr_edge & udr_armed;
  assign uir_rise = uir_out & ~uir_edge & uir_armed;
  // Synchronisers and edge registers; fill marks when the chains hold real samples,
  // so arming waits for a genuine low and a strobe already high at reset is ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      udr_sync  <= '0;
      uir_sync  <= '0;
      fill      <= '0;
      udr_edge  <= 1'b0;
      uir_edge  <= 1'b0;
      udr_armed <= 1'b0;
      uir_armed <= 1'b0;
    end else begin
      udr_sync  <= {udr_sync[SYNC_DEPTH-2:0], vs_udr};
      uir_sync  <= {uir_sync[SYNC_DEPTH-2:0], vs_uir};
      fill      <= {fill[SYNC_DEPTH-2:0], 1'b1};
      udr_edge  <= udr_out;
      uir_edge  <= uir_out;
      udr_armed <= udr_armed | (fill[SYNC_DEPTH-1] & ~udr_out);
      uir_armed <= uir_armed | (fill[SYNC_DEPTH-1] & ~uir_out);
    end
  end
  assign pop     = cmd_valid & cmd_ready;
  assign push_ok = udr_rise & ((count != LW'(QUEUE_DEPTH)) | pop);
  assign drop    = udr_rise & ~push_ok;
  // Command FIFO: storage, pointers, count and sticky overflow (set beats clear)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) mem[i] <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) mem[wr_ptr] <= {ir_in, sr};
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count    <= count + LW'(push_ok) - LW'(pop);
      overflow <= drop | (overflow & ~overflow_clr);
    end
  end
  // Update-IR pulse and captured instruction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_update  <= 1'b0;
      ir_latched <= '0;
    end else begin
      ir_update  <= uir_rise;
      ir_latched <= uir_rise ? ir_in : ir_latched;
    end
  end
  assign {cmd_ir, jdo} = mem[rd_ptr];
  assign cmd_valid     = count != '0;
  assign queue_level   = count;
  assign cmd_onehot    = {{(NL-1){1'b0}}, cmd_valid} << cmd_ir;
endmodule
